// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive-path types and defaults
package uart_pkg;
  localparam int FIFO_DEPTH = 8;
  typedef enum logic {IDLE, ACK} cap_state_t;
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/rx_fifo_mem.sv
// rx_fifo_mem: DEPTH x 8 storage, one synchronous write port, one asynchronous read port
module rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  byte_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/rx_fifo.sv
// rx_fifo: UART receive FIFO with one-shot capture handshake and sticky overrun flag
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rda,
  input  logic [7:0]             receive_read_line,
  output logic                   receive_read_en,
  input  logic                   pop,
  output logic [7:0]             rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  input  logic                   overrun_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  cap_state_t state, state_nx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] head;
  logic push, do_pop, drop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = (state == IDLE && rda) ? ACK : IDLE;
  // the ack is gated by rst_n so nothing is acknowledged while reset is held
  always_comb receive_read_en = rst_n && state == IDLE && rda;
  assign empty  = count == '0;
  assign full   = count == CW'(DEPTH);
  assign push   = receive_read_en && (!full || pop);
  assign do_pop = pop && !empty;
  assign drop   = receive_read_en && full && !pop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push);
      rd_ptr  <= rd_ptr + AW'(do_pop);
      count   <= count + CW'(push) - CW'(do_pop);
      overrun <= drop ? 1'b1 : overrun_clr ? 1'b0 : overrun;
    end
  rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(receive_read_line),
    .raddr(rd_ptr),
    .rdata(head)
  );
  assign rdata = empty ? 8'h00 : head;
endmodule
